// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register with a 2-entry skid buffer.
// The main slot drives the outputs and the skid slot catches the one entry
// accepted while the downstream stalls. in_ready comes straight from a flop.
module pipe_skid_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_data0,
  input  logic [DATA_W-1:0]     in_data1,
  input  logic [REG_ADDR_W-1:0] in_dst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_data0,
  output logic [DATA_W-1:0]     out_data1,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic [1:0]            occupancy
);

  logic                  main_valid;
  logic [CTRL_W-1:0]     main_ctrl;
  logic [DATA_W-1:0]     main_data0;
  logic [DATA_W-1:0]     main_data1;
  logic [REG_ADDR_W-1:0] main_dst;

  logic                  skid_valid;
  logic [CTRL_W-1:0]     skid_ctrl;
  logic [DATA_W-1:0]     skid_data0;
  logic [DATA_W-1:0]     skid_data1;
  logic [REG_ADDR_W-1:0] skid_dst;

  logic                  ready_q;
  logic                  accept;
  logic                  drain;

  // Handshake qualifiers; both depend only on flops plus external inputs.
  always_comb begin
    accept = in_valid & ready_q;
    drain  = main_valid & out_ready;
  end

  // Slot valids and the registered ready; ready_q always equals !skid_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (!main_valid) begin
      main_valid <= accept;
    end else if (!skid_valid) begin
      if (accept && !drain) begin
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end else if (!accept && drain) begin
        main_valid <= 1'b0;
      end
    end else if (drain) begin
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end
  end

  // Main payload: loads from the input on accept into an empty or draining
  // slot, or from the skid slot when a full stage drains; otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl  <= '0;
      main_data0 <= '0;
      main_data1 <= '0;
      main_dst   <= '0;
    end else if (!flush) begin
      if (skid_valid) begin
        if (drain) begin
          main_ctrl  <= skid_ctrl;
          main_data0 <= skid_data0;
          main_data1 <= skid_data1;
          main_dst   <= skid_dst;
        end
      end else if (accept && (!main_valid || drain)) begin
        main_ctrl  <= in_ctrl;
        main_data0 <= in_data0;
        main_data1 <= in_data1;
        main_dst   <= in_dst;
      end
    end
  end

  // Skid payload: captures the entry accepted while the main slot stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ctrl  <= '0;
      skid_data0 <= '0;
      skid_data1 <= '0;
      skid_dst   <= '0;
    end else if (!flush && main_valid && !skid_valid && accept && !drain) begin
      skid_ctrl  <= in_ctrl;
      skid_data0 <= in_data0;
      skid_data1 <= in_data1;
      skid_dst   <= in_dst;
    end
  end

  // Output drive; only the ctrl bundle is replaced by the bubble pattern.
  always_comb begin
    in_ready  = ready_q;
    out_valid = main_valid;
    out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
    out_data0 = main_data0;
    out_data1 = main_data1;
    out_dst   = main_dst;
    occupancy = {skid_valid, main_valid & ~skid_valid};
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised elastic pipeline stage register that replaces fixed write-enable stage registers (such as the MEM/WB register) between pipeline stages of the 16-bit core.
- Carries a control bundle, two data words and a destination register address.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is driven from a flop.
- Supports flush and forces a bubble control pattern whenever no valid entry is presented.

Parameters:
DATA_W, 16, width of each data word (ALU result, memory read data)
CTRL_W, 8, width of control bundle (rf_write, memtoreg, branch[2:0], spare)
REG_ADDR_W, 4, width of destination register address
BUBBLE_CTRL, 0, value driven on out_ctrl when out_valid=0 (all writes/branches off)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries, synchronous
in_valid  in  1  upstream offers an entry
in_ready  out  1  stage can accept; registered (=!skid_valid)
in_ctrl  in  CTRL_W  control bundle of offered entry
in_data0  in  DATA_W  data word 0 (result)
in_data1  in  DATA_W  data word 1 (dm data)
in_dst  in  REG_ADDR_W  destination register
out_valid  out  1  main slot holds a valid entry
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  main ctrl if valid, else BUBBLE_CTRL
out_data0  out  DATA_W  main slot data word 0
out_data1  out  DATA_W  main slot data word 1
out_dst  out  REG_ADDR_W  main slot destination
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main slot (drives outputs) plus skid slot; each slot has a valid flag plus ctrl/data0/data1/dst.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- States (occupancy):
  - EMPTY (0)
  - ONE (main valid)
  - FULL (main+skid valid)
- EMPTY:
  - accept -> entry to main, ONE.
  - Otherwise stay EMPTY.
- ONE:
  - accept & drain -> new entry to main, stay ONE.
  - accept only -> entry to skid, FULL.
  - drain only -> EMPTY.
  - Neither -> hold.
- FULL:
  - in_ready=0, so no accept.
  - drain -> skid moves to main, skid cleared, ONE.
  - Otherwise hold all fields.
- Ordering is strict FIFO; an entry never bypasses combinationally from input to output.
- Latency: minimum 1 cycle (accept at edge N, out_valid high after edge N).
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready changes only at clock edges: 1 in EMPTY/ONE, 0 in FULL.
- Payload regs load only on accept/shift; they are never modified otherwise. Ctrl flops always carry entries; the BUBBLE_CTRL mux is output-only.
- out_ctrl = BUBBLE_CTRL whenever out_valid=0. out_data0/out_data1/out_dst keep their last values when invalid; consumers must gate on out_valid.
- flush: next state EMPTY regardless of accept/drain that cycle.
  - An entry offered in the flush cycle is dropped.
  - in_ready=1 the following cycle.
  - Payload regs are not cleared.
- rst (sync): both valids cleared and all payload regs cleared to 0, giving:
  - out_valid=0, in_ready=1, occupancy=0
  - out_ctrl=BUBBLE_CTRL, out_data0/1=0, out_dst=0
- Priority: rst > flush > handshake.
- rst asserted mid-transfer drops all entries; no partial state survives.
- No X propagation: payload muxes select only between in_* and skid.

Test Plan:
- Reset then idle: rst=1 one cycle -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=0x00, out_data0=0x0000.
- Streaming: out_ready=1, offer 4 entries data0=0x0011..0x0044 back-to-back -> out_valid from cycle+1, data0 0x0011,0x0022,0x0033,0x0044 on consecutive cycles, in_ready stays 1, occupancy=1.
- Backpressure: out_ready=0, offer 0xAAAA then 0xBBBB then 0xCCCC -> occupancy 1 then 2; in_ready=0 after second accept; 0xCCCC held off. Then out_ready=1 -> outputs 0xAAAA, 0xBBBB, 0xCCCC in order with no loss or duplicate.
- Flush while FULL with in_valid=1 (data0=0xDEAD) -> next cycle occupancy=0, out_valid=0, out_ctrl=BUBBLE_CTRL, 0xDEAD never appears on the output.
- Bubble ctrl: BUBBLE_CTRL=0x00, in_ctrl=0xC1 with gap cycles -> out_ctrl=0xC1 only while out_valid=1, else 0x00.
- Reset mid-operation: FULL with 0x1234/0x5678 held, assert rst -> next cycle empty, all payload outputs 0, neither value ever output.
